// File: rtl/vai_rx_demux_if.sv
// CCI-P Rx bundle for the VAI Rx demux: one upstream port from the manager,
// per-AFU downstream ports, and the demux status outputs.
interface vai_rx_demux_if #(
   parameter int unsigned NUM_SUB_AFUS = 9,
   parameter int unsigned CNT_WIDTH    = 32
);
   // Upstream Rx from the manager
   logic          up_c0RspValid;
   logic          up_c0MmioRdValid;
   logic          up_c0MmioWrValid;
   logic [15:0]   up_c0Mdata;
   logic [3:0]    up_c0RspType;
   logic [1:0]    up_c0ClNum;
   logic [15:0]   up_c0MmioAddr;
   logic [1:0]    up_c0MmioLen;
   logic [8:0]    up_c0MmioTid;
   logic [511:0]  up_c0Data;
   logic          up_c1RspValid;
   logic [15:0]   up_c1Mdata;
   logic [3:0]    up_c1RspType;
   logic          up_c1Format;
   logic [1:0]    up_c1ClNum;
   logic          up_c0TxAlmFull;
   logic          up_c1TxAlmFull;

   // Per-AFU Rx
   logic [NUM_SUB_AFUS-1:0]         afu_c0RspValid;
   logic [NUM_SUB_AFUS-1:0]         afu_c0MmioRdValid;
   logic [NUM_SUB_AFUS-1:0]         afu_c0MmioWrValid;
   logic [NUM_SUB_AFUS-1:0][15:0]   afu_c0Mdata;
   logic [NUM_SUB_AFUS-1:0][3:0]    afu_c0RspType;
   logic [NUM_SUB_AFUS-1:0][1:0]    afu_c0ClNum;
   logic [NUM_SUB_AFUS-1:0][15:0]   afu_c0MmioAddr;
   logic [NUM_SUB_AFUS-1:0][1:0]    afu_c0MmioLen;
   logic [NUM_SUB_AFUS-1:0][8:0]    afu_c0MmioTid;
   logic [NUM_SUB_AFUS-1:0][511:0]  afu_c0Data;
   logic [NUM_SUB_AFUS-1:0]         afu_c1RspValid;
   logic [NUM_SUB_AFUS-1:0][15:0]   afu_c1Mdata;
   logic [NUM_SUB_AFUS-1:0][3:0]    afu_c1RspType;
   logic [NUM_SUB_AFUS-1:0]         afu_c1Format;
   logic [NUM_SUB_AFUS-1:0][1:0]    afu_c1ClNum;
   logic [NUM_SUB_AFUS-1:0]         afu_c0TxAlmFull;
   logic [NUM_SUB_AFUS-1:0]         afu_c1TxAlmFull;

   // Status
   logic [NUM_SUB_AFUS-1:0][CNT_WIDTH-1:0] rsp_count;
   logic          err_bad_tag;
   logic          err_bad_mmio;
   logic          bad_mmio_rd;
   logic [8:0]    bad_mmio_tid;

   modport master (
      output up_c0RspValid, up_c0MmioRdValid, up_c0MmioWrValid, up_c0Mdata, up_c0RspType,
             up_c0ClNum, up_c0MmioAddr, up_c0MmioLen, up_c0MmioTid, up_c0Data, up_c1RspValid,
             up_c1Mdata, up_c1RspType, up_c1Format, up_c1ClNum, up_c0TxAlmFull, up_c1TxAlmFull,
      input  afu_c0RspValid, afu_c0MmioRdValid, afu_c0MmioWrValid, afu_c0Mdata, afu_c0RspType,
             afu_c0ClNum, afu_c0MmioAddr, afu_c0MmioLen, afu_c0MmioTid, afu_c0Data,
             afu_c1RspValid, afu_c1Mdata, afu_c1RspType, afu_c1Format, afu_c1ClNum,
             afu_c0TxAlmFull, afu_c1TxAlmFull,
             rsp_count, err_bad_tag, err_bad_mmio, bad_mmio_rd, bad_mmio_tid
   );

   modport slave (
      input  up_c0RspValid, up_c0MmioRdValid, up_c0MmioWrValid, up_c0Mdata, up_c0RspType,
             up_c0ClNum, up_c0MmioAddr, up_c0MmioLen, up_c0MmioTid, up_c0Data, up_c1RspValid,
             up_c1Mdata, up_c1RspType, up_c1Format, up_c1ClNum, up_c0TxAlmFull, up_c1TxAlmFull,
      output afu_c0RspValid, afu_c0MmioRdValid, afu_c0MmioWrValid, afu_c0Mdata, afu_c0RspType,
             afu_c0ClNum, afu_c0MmioAddr, afu_c0MmioLen, afu_c0MmioTid, afu_c0Data,
             afu_c1RspValid, afu_c1Mdata, afu_c1RspType, afu_c1Format, afu_c1ClNum,
             afu_c0TxAlmFull, afu_c1TxAlmFull,
             rsp_count, err_bad_tag, err_bad_mmio, bad_mmio_rd, bad_mmio_tid
   );
endinterface

// File: rtl/vai_rx_demux.sv
// VAI Rx demux: routes upstream CCI-P Rx responses to sub-AFUs by mdata tag and
// MMIO requests by address window, through a fixed two-stage pipeline.
module vai_rx_demux #(
   parameter int unsigned NUM_SUB_AFUS = 9,
   parameter int unsigned TAG_LSB      = 12,
   parameter int unsigned TAG_BITS     = 4,
   parameter int unsigned MMIO_SEL_LSB = 12,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input logic            pClk,
   input logic            SoftReset,
   vai_rx_demux_if.slave  rxIf
);
   localparam int unsigned NA = NUM_SUB_AFUS;
   localparam logic [TAG_BITS:0] NumAfus = (TAG_BITS + 1)'(NUM_SUB_AFUS);
   localparam logic [15:0] TagMask = 16'(((1 << TAG_BITS) - 1) << TAG_LSB);
   localparam logic [15:0] SelMask = 16'(((1 << TAG_BITS) - 1) << MMIO_SEL_LSB);

   // Index decode on the raw input
   logic [TAG_BITS-1:0] c0Idx, c1Idx, mmioSel;
   logic                c0Ok, c1Ok, mmioOk;

   assign c0Idx   = rxIf.up_c0Mdata[TAG_LSB +: TAG_BITS];
   assign c1Idx   = rxIf.up_c1Mdata[TAG_LSB +: TAG_BITS];
   assign mmioSel = rxIf.up_c0MmioAddr[MMIO_SEL_LSB +: TAG_BITS];
   assign c0Ok    = {1'b0, c0Idx} < NumAfus;
   assign c1Ok    = {1'b0, c1Idx} < NumAfus;
   assign mmioOk  = {1'b0, mmioSel} < NumAfus;

   // Stage 1
   logic s1C0Fwd, s1C0Bad, s1C1Fwd, s1C1Bad, s1RdFwd, s1WrFwd, s1RdBad, s1MmioBad;
   logic s1AlmFull0, s1AlmFull1;
   logic [TAG_BITS-1:0] s1C0Idx, s1C1Idx, s1Sel;
   logic [15:0]  s1C0Mdata, s1MmioAddr, s1C1Mdata;
   logic [3:0]   s1C0RspType, s1C1RspType;
   logic [1:0]   s1C0ClNum, s1MmioLen, s1C1ClNum;
   logic [8:0]   s1MmioTid;
   logic [511:0] s1C0Data;
   logic         s1C1Format;

   // Stage 2
   logic [NA-1:0] s2C0Valid, s2C1Valid, s2RdValid, s2WrValid;
   logic          s2AlmFull0, s2AlmFull1, errBadTag, errBadMmio, badRd;
   logic [15:0]   s2C0Mdata, s2MmioAddr, s2C1Mdata;
   logic [3:0]    s2C0RspType, s2C1RspType;
   logic [1:0]    s2C0ClNum, s2MmioLen, s2C1ClNum;
   logic [8:0]    s2MmioTid, badTid;
   logic [511:0]  s2C0Data;
   logic          s2C1Format;
   logic [NA-1:0][CNT_WIDTH-1:0] cntQ, cntD;

   logic [NA-1:0] c0Hit, c1Hit, rdHit, wrHit;

   always_comb begin
      c0Hit = '0;
      c1Hit = '0;
      rdHit = '0;
      wrHit = '0;
      cntD  = cntQ;
      for (int i = 0; i < NA; i++) begin
         c0Hit[i] = s1C0Fwd && (s1C0Idx == TAG_BITS'(i));
         c1Hit[i] = s1C1Fwd && (s1C1Idx == TAG_BITS'(i));
         rdHit[i] = s1RdFwd && (s1Sel == TAG_BITS'(i));
         wrHit[i] = s1WrFwd && (s1Sel == TAG_BITS'(i));
         // c0 and c1 to the same AFU in one cycle add 2
         cntD[i]  = cntQ[i] + CNT_WIDTH'(c0Hit[i]) + CNT_WIDTH'(c1Hit[i]);
      end
   end

   always_ff @(posedge pClk) begin
      if (SoftReset) begin
         s1C0Fwd    <= 1'b0;
         s1C0Bad    <= 1'b0;
         s1C1Fwd    <= 1'b0;
         s1C1Bad    <= 1'b0;
         s1RdFwd    <= 1'b0;
         s1WrFwd    <= 1'b0;
         s1RdBad    <= 1'b0;
         s1MmioBad  <= 1'b0;
         s1AlmFull0 <= 1'b1;
         s1AlmFull1 <= 1'b1;
         s2C0Valid  <= '0;
         s2C1Valid  <= '0;
         s2RdValid  <= '0;
         s2WrValid  <= '0;
         s2AlmFull0 <= 1'b1;
         s2AlmFull1 <= 1'b1;
         errBadTag  <= 1'b0;
         errBadMmio <= 1'b0;
         badRd      <= 1'b0;
         cntQ       <= '0;
      end else begin
         s1C0Fwd    <= rxIf.up_c0RspValid && c0Ok;
         s1C0Bad    <= rxIf.up_c0RspValid && !c0Ok;
         s1C1Fwd    <= rxIf.up_c1RspValid && c1Ok;
         s1C1Bad    <= rxIf.up_c1RspValid && !c1Ok;
         s1RdFwd    <= rxIf.up_c0MmioRdValid && mmioOk;
         s1WrFwd    <= rxIf.up_c0MmioWrValid && mmioOk;
         s1RdBad    <= rxIf.up_c0MmioRdValid && !mmioOk;
         s1MmioBad  <= (rxIf.up_c0MmioRdValid || rxIf.up_c0MmioWrValid) && !mmioOk;
         s1AlmFull0 <= rxIf.up_c0TxAlmFull;
         s1AlmFull1 <= rxIf.up_c1TxAlmFull;
         s2C0Valid  <= c0Hit;
         s2C1Valid  <= c1Hit;
         s2RdValid  <= rdHit;
         s2WrValid  <= wrHit;
         s2AlmFull0 <= s1AlmFull0;
         s2AlmFull1 <= s1AlmFull1;
         errBadTag  <= errBadTag | s1C0Bad | s1C1Bad;
         errBadMmio <= errBadMmio | s1MmioBad;
         badRd      <= s1RdBad;
         cntQ       <= cntD;
      end
   end

   // Payload needs no reset; only the valids qualify it
   always_ff @(posedge pClk) begin
      s1C0Idx     <= c0Idx;
      s1C1Idx     <= c1Idx;
      s1Sel       <= mmioSel;
      s1C0Mdata   <= rxIf.up_c0Mdata & ~TagMask;
      s1C0RspType <= rxIf.up_c0RspType;
      s1C0ClNum   <= rxIf.up_c0ClNum;
      s1MmioAddr  <= rxIf.up_c0MmioAddr & ~SelMask;
      s1MmioLen   <= rxIf.up_c0MmioLen;
      s1MmioTid   <= rxIf.up_c0MmioTid;
      s1C0Data    <= rxIf.up_c0Data;
      s1C1Mdata   <= rxIf.up_c1Mdata & ~TagMask;
      s1C1RspType <= rxIf.up_c1RspType;
      s1C1Format  <= rxIf.up_c1Format;
      s1C1ClNum   <= rxIf.up_c1ClNum;
      s2C0Mdata   <= s1C0Mdata;
      s2C0RspType <= s1C0RspType;
      s2C0ClNum   <= s1C0ClNum;
      s2MmioAddr  <= s1MmioAddr;
      s2MmioLen   <= s1MmioLen;
      s2MmioTid   <= s1MmioTid;
      s2C0Data    <= s1C0Data;
      s2C1Mdata   <= s1C1Mdata;
      s2C1RspType <= s1C1RspType;
      s2C1Format  <= s1C1Format;
      s2C1ClNum   <= s1C1ClNum;
      badTid      <= s1MmioTid;
   end

   assign rxIf.afu_c0RspValid    = s2C0Valid;
   assign rxIf.afu_c1RspValid    = s2C1Valid;
   assign rxIf.afu_c0MmioRdValid = s2RdValid;
   assign rxIf.afu_c0MmioWrValid = s2WrValid;
   assign rxIf.rsp_count         = cntQ;
   assign rxIf.err_bad_tag       = errBadTag;
   assign rxIf.err_bad_mmio      = errBadMmio;
   assign rxIf.bad_mmio_rd       = badRd;
   assign rxIf.bad_mmio_tid      = badTid;

   // Payload is broadcast; non-selected AFUs ignore it
   for (genvar g = 0; g < NA; g++) begin : gen_afu
      assign rxIf.afu_c0Mdata[g]     = s2C0Mdata;
      assign rxIf.afu_c0RspType[g]   = s2C0RspType;
      assign rxIf.afu_c0ClNum[g]     = s2C0ClNum;
      assign rxIf.afu_c0MmioAddr[g]  = s2MmioAddr;
      assign rxIf.afu_c0MmioLen[g]   = s2MmioLen;
      assign rxIf.afu_c0MmioTid[g]   = s2MmioTid;
      assign rxIf.afu_c0Data[g]      = s2C0Data;
      assign rxIf.afu_c1Mdata[g]     = s2C1Mdata;
      assign rxIf.afu_c1RspType[g]   = s2C1RspType;
      assign rxIf.afu_c1Format[g]    = s2C1Format;
      assign rxIf.afu_c1ClNum[g]     = s2C1ClNum;
      assign rxIf.afu_c0TxAlmFull[g] = s2AlmFull0;
      assign rxIf.afu_c1TxAlmFull[g] = s2AlmFull1;
   end
endmodule
